// File: rtl/alu_share_arbiter.sv
// Purpose: shares one combinational ALU between two requesters.
//          Requester 0 is the execute stage. Requester 1 is the address/branch-target helper.
//          Round-robin arbitration is used, and the ALU result is registered and
//          returned on a single response channel that supports backpressure.
// Ports:
//   clk, rst_n                       clock; asynchronous active-low reset
//   req{0,1}_valid/_ready            per-requester handshake (ready is combinational)
//   req{0,1}_in_0/_in_1/_op          per-requester operands and op code
//   alu_in_0/alu_in_1/alu_operation  drive to the shared ALU (zero when idle)
//   alu_out                          shared ALU result
//   rsp_valid/rsp_ready              response handshake
//   rsp_id/rsp_data                  owning requester and registered result
module alu_share_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_in_0,
    input  logic [XLEN-1:0] req0_in_1,
    input  logic [OPW-1:0]  req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_in_0,
    input  logic [XLEN-1:0] req1_in_1,
    input  logic [OPW-1:0]  req1_op,
    output logic [XLEN-1:0] alu_in_0,
    output logic [XLEN-1:0] alu_in_1,
    output logic [OPW-1:0]  alu_operation,
    input  logic [XLEN-1:0] alu_out,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   free_c;
    logic   grant_vld_c;
    logic   grant_id_c;

    // Response slot occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, ALU drive and next-state decision
    always_comb begin
        state_nxt     = state;
        free_c        = 1'b0;
        grant_vld_c   = 1'b0;
        grant_id_c    = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        alu_in_0      = '0;
        alu_in_1      = '0;
        alu_operation = '0;

        // The slot can take a new result if it is empty or being drained this cycle
        free_c = (state == EMPTY) || rsp_ready;

        if (free_c) begin
            if (req0_valid && req1_valid) begin
                grant_vld_c = 1'b1;
                grant_id_c  = ~last_grant;
            end else if (req0_valid) begin
                grant_vld_c = 1'b1;
                grant_id_c  = 1'b0;
            end else if (req1_valid) begin
                grant_vld_c = 1'b1;
                grant_id_c  = 1'b1;
            end
        end

        if (grant_vld_c) begin
            if (grant_id_c == 1'b0) begin
                req0_ready    = 1'b1;
                alu_in_0      = req0_in_0;
                alu_in_1      = req0_in_1;
                alu_operation = req0_op;
            end else begin
                req1_ready    = 1'b1;
                alu_in_0      = req1_in_0;
                alu_in_1      = req1_in_1;
                alu_operation = req1_op;
            end
        end

        case (state)
            EMPTY: begin
                if (grant_vld_c) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                // A drain without a replacing accept empties the slot
                if (!grant_vld_c && rsp_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Result capture and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant_vld_c) begin
            rsp_data   <= alu_out;
            rsp_id     <= grant_id_c;
            last_grant <= grant_id_c;
        end
    end

    assign rsp_valid = (state == FULL);

endmodule
